passcode_checker: RTL and testbench

- Keypad decision stage of the six-digit electronic lock, directly upstream of the LED flasher.
- Collects decoded key events into a six-digit BCD entry buffer and compares it against a stored passcode on confirm.
- Drives the level `unlock` that the flasher uses as its switch input, and tracks consecutive failures up to an alarm lockout.
- Also supports changing the passcode while unlocked.

---
 rtl/lock_pkg.sv | 19 +
 rtl/entry_buffer.sv | 40 ++++
 rtl/passcode_checker.sv | 141 ++++++++++++++
 tb/tb_passcode_checker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the six-digit keypad lock: key codes, FSM states and
// the default passcode length.
package lock_pkg;

    localparam int LOCK_DIGITS = 6;

    localparam logic [3:0] KEY_BKSP = 4'hA;
    localparam logic [3:0] KEY_OK   = 4'hB;
    localparam logic [3:0] KEY_LOCK = 4'hC;
    localparam logic [3:0] KEY_CHG  = 4'hD;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        SET_PW   = 2'd2,
        ALARM    = 2'd3
    } state_e;

endpackage

// File: rtl/entry_buffer.sv
// BCD entry shift register with digit counter; newest digit lands in the low
// nibble, backspace drops it again. clear wins over push, push over pop.
module entry_buffer
    import lock_pkg::*;
#(
    parameter int DIGITS = LOCK_DIGITS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [3:0]                     digit,
    input  logic                           pop,
    input  logic                           clear,
    output logic [4*DIGITS-1:0]            buffer,
    output logic [$clog2(DIGITS+1)-1:0]    count,
    output logic                           full
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

    assign full = (count == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buffer <= '0;
            count  <= '0;
        end else if (clear) begin
            buffer <= '0;
            count  <= '0;
        end else if (push && !full) begin
            buffer <= {buffer[4*DIGITS-5:0], digit};
            count  <= count + CW'(1);
        end else if (pop && (count != '0)) begin
            buffer <= buffer >> 4;
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/passcode_checker.sv
// Keypad decision FSM: compares the entry buffer to the stored passcode,
// counts consecutive failures into an alarm lockout, and allows passcode change.
module passcode_checker
    import lock_pkg::*;
#(
    parameter int                      DIGITS     = LOCK_DIGITS,
    parameter int                      MAX_FAIL   = 3,
    parameter logic [4*DIGITS-1:0]     DEFAULT_PW = 24'h123456
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             key_valid,
    input  logic [3:0]                       key_code,
    input  logic                             alarm_clr,
    output logic                             unlock,
    output logic                             alarm,
    output logic                             err_pulse,
    output logic                             pw_set_pulse,
    output logic [$clog2(DIGITS+1)-1:0]      digit_count,
    output logic [$clog2(MAX_FAIL+1)-1:0]    fail_count
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam logic [FW-1:0] FAIL_LIM = FW'(MAX_FAIL);

    state_e               state, state_nxt;
    logic [4*DIGITS-1:0]  passcode, passcode_nxt;
    logic [FW-1:0]        fails, fails_nxt;
    logic                 err_nxt, pw_set_nxt;
    logic                 buf_push, buf_pop, buf_clear, buf_full;
    logic [4*DIGITS-1:0]  buf_value;
    logic                 is_digit;

    function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
        return (v == FAIL_LIM) ? v : v + FW'(1);
    endfunction

    entry_buffer #(.DIGITS(DIGITS)) u_entry_buffer (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (buf_push),
        .digit  (key_code),
        .pop    (buf_pop),
        .clear  (buf_clear),
        .buffer (buf_value),
        .count  (digit_count),
        .full   (buf_full)
    );

    assign is_digit = (key_code <= 4'd9);

    always_comb begin
        state_nxt    = state;
        passcode_nxt = passcode;
        fails_nxt    = fails;
        err_nxt      = 1'b0;
        pw_set_nxt   = 1'b0;
        buf_push     = 1'b0;
        buf_pop      = 1'b0;
        buf_clear    = 1'b0;

        // ALARM swallows every key; only the supervisor's clear gets out
        if (state == ALARM) begin
            if (alarm_clr) begin
                state_nxt = ENTRY;
                fails_nxt = '0;
                buf_clear = 1'b1;
            end
        end else if (key_valid) begin
            case (state)
                ENTRY: begin
                    if (is_digit) begin
                        buf_push = 1'b1;
                    end else if (key_code == KEY_BKSP) begin
                        buf_pop = 1'b1;
                    end else if (key_code == KEY_OK) begin
                        buf_clear = 1'b1;
                        if (buf_full && (buf_value == passcode)) begin
                            state_nxt = UNLOCKED;
                            fails_nxt = '0;
                        end else begin
                            err_nxt   = 1'b1;
                            fails_nxt = sat_inc(fails);
                            if (fails_nxt == FAIL_LIM) state_nxt = ALARM;
                        end
                    end else if (key_code == KEY_LOCK) begin
                        buf_clear = 1'b1;
                    end
                end
                UNLOCKED: begin
                    if (key_code == KEY_LOCK)     state_nxt = ENTRY;
                    else if (key_code == KEY_CHG) state_nxt = SET_PW;
                end
                SET_PW: begin
                    if (is_digit) begin
                        buf_push = 1'b1;
                    end else if (key_code == KEY_BKSP) begin
                        buf_pop = 1'b1;
                    end else if (key_code == KEY_OK) begin
                        buf_clear = 1'b1;
                        if (buf_full) begin
                            passcode_nxt = buf_value;
                            pw_set_nxt   = 1'b1;
                            state_nxt    = UNLOCKED;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (key_code == KEY_LOCK) begin
                        buf_clear = 1'b1;
                        state_nxt = ENTRY;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Outputs are registered from the next-state decode so they line up with state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ENTRY;
            passcode     <= DEFAULT_PW;
            fails        <= '0;
            unlock       <= 1'b0;
            alarm        <= 1'b0;
            err_pulse    <= 1'b0;
            pw_set_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            passcode     <= passcode_nxt;
            fails        <= fails_nxt;
            unlock       <= (state_nxt == UNLOCKED) || (state_nxt == SET_PW);
            alarm        <= (state_nxt == ALARM);
            err_pulse    <= err_nxt;
            pw_set_pulse <= pw_set_nxt;
        end
    end

    assign fail_count = fails;

endmodule

// File: tb/tb_passcode_checker.sv
// Self-checking bench for passcode_checker: directed scenarios followed by
// randomized key traffic, all compared against a queue-based lock model.
module tb_passcode_checker;

    logic       clk;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       alarm_clr;
    logic       unlock;
    logic       alarm;
    logic       err_pulse;
    logic       pw_set_pulse;
    logic [2:0] digit_count;
    logic [1:0] fail_count;

    int n_vec;
    int n_bad;

    // Reference model: 0=entry 1=unlocked 2=set-passcode 3=alarm
    int m_st;
    int m_q[$];
    int m_pw[6];
    int m_fail;
    int m_err;
    int m_pws;

    passcode_checker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .alarm_clr    (alarm_clr),
        .unlock       (unlock),
        .alarm        (alarm),
        .err_pulse    (err_pulse),
        .pw_set_pulse (pw_set_pulse),
        .digit_count  (digit_count),
        .fail_count   (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0;
        m_q.delete();
        m_fail = 0;
        m_err = 0;
        m_pws = 0;
        m_pw = '{1, 2, 3, 4, 5, 6};
    endtask

    function automatic bit entry_matches();
        if (m_q.size() != 6) return 1'b0;
        for (int i = 0; i < 6; i++)
            if (m_q[i] != m_pw[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit kv, input int code, input bit ac);
        m_err = 0;
        m_pws = 0;
        if (m_st == 3) begin
            if (ac) begin
                m_st = 0;
                m_fail = 0;
                m_q.delete();
            end
        end else if (kv) begin
            if (m_st == 0 || m_st == 2) begin
                if (code <= 9) begin
                    if (m_q.size() < 6) m_q.push_back(code);
                end else if (code == 10) begin
                    if (m_q.size() > 0) void'(m_q.pop_back());
                end else if (code == 11) begin
                    if (m_st == 0) begin
                        if (entry_matches()) begin
                            m_st = 1;
                            m_fail = 0;
                        end else begin
                            m_err = 1;
                            m_fail = m_fail + 1;
                            if (m_fail == 3) m_st = 3;
                        end
                    end else if (m_q.size() == 6) begin
                        for (int i = 0; i < 6; i++) m_pw[i] = m_q[i];
                        m_pws = 1;
                        m_st = 1;
                    end else begin
                        m_err = 1;
                    end
                    m_q.delete();
                end else if (code == 12) begin
                    m_q.delete();
                    m_st = 0;
                end
            end else if (m_st == 1) begin
                if (code == 12) m_st = 0;
                else if (code == 13) m_st = 2;
            end
        end
    endtask

    task automatic check_outputs();
        chk("unlock", int'(unlock), (m_st == 1 || m_st == 2) ? 1 : 0);
        chk("alarm", int'(alarm), (m_st == 3) ? 1 : 0);
        chk("err_pulse", int'(err_pulse), m_err);
        chk("pw_set_pulse", int'(pw_set_pulse), m_pws);
        chk("digit_count", int'(digit_count), m_q.size());
        chk("fail_count", int'(fail_count), m_fail);
    endtask

    task automatic cycle(input bit kv, input int code, input bit ac);
        @(negedge clk);
        rst_n = 1'b1;
        key_valid = kv;
        key_code = 4'(code);
        alarm_clr = ac;
        @(posedge clk);
        model_step(kv, code, ac);
        #1;
        check_outputs();
    endtask

    task automatic key(input int code);
        cycle(1'b1, code, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        key_valid = 1'b0;
        alarm_clr = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_outputs();
    endtask

    task automatic enter_code(input int d0, d1, d2, d3, d4, d5);
        key(d0); key(d1); key(d2); key(d3); key(d4); key(d5);
    endtask

    int exp_cnt[10];
    int seq[10];

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        key_valid = 1'b0;
        key_code = 4'h0;
        alarm_clr = 1'b0;
        model_reset();

        // Correct default code unlocks
        do_reset();
        chk("rst_unlock", int'(unlock), 0);
        chk("rst_digits", int'(digit_count), 0);
        enter_code(1, 2, 3, 4, 5, 6);
        key(11);
        chk("t1_unlock", int'(unlock), 1);
        chk("t1_fail", int'(fail_count), 0);

        // Two wrong then right
        do_reset();
        enter_code(1, 2, 3, 4, 5, 7); key(11);
        chk("t2_err1", int'(err_pulse), 1);
        chk("t2_fail1", int'(fail_count), 1);
        enter_code(1, 2, 3, 4, 5, 7); key(11);
        chk("t2_fail2", int'(fail_count), 2);
        enter_code(1, 2, 3, 4, 5, 6); key(11);
        chk("t2_unlock", int'(unlock), 1);
        chk("t2_fail0", int'(fail_count), 0);

        // Three failures -> alarm, keys ignored, alarm_clr with key
        do_reset();
        enter_code(9, 9, 9, 9, 9, 9); key(11);
        key(1); key(2); key(3); key(4); key(11);
        enter_code(0, 0, 0, 0, 0, 0); key(11);
        chk("t3_alarm", int'(alarm), 1);
        chk("t3_fail3", int'(fail_count), 3);
        enter_code(1, 2, 3, 4, 5, 6); key(11);
        chk("t3_locked", int'(unlock), 0);
        cycle(1'b1, 1, 1'b1);
        chk("t3_clr_alarm", int'(alarm), 0);
        chk("t3_clr_fail", int'(fail_count), 0);
        chk("t3_clr_digits", int'(digit_count), 0);

        // Backspace and overflow
        do_reset();
        seq = '{1, 2, 3, 9, 10, 4, 5, 6, 7, 8};
        exp_cnt = '{1, 2, 3, 4, 3, 4, 5, 6, 6, 6};
        for (int i = 0; i < 10; i++) begin
            key(seq[i]);
            chk("t4_count", int'(digit_count), exp_cnt[i]);
        end
        key(11);
        chk("t4_unlock", int'(unlock), 1);

        // Change passcode, relock, old rejected, new accepted
        key(13);
        enter_code(6, 5, 4, 3, 2, 1); key(11);
        chk("t5_pwset", int'(pw_set_pulse), 1);
        chk("t5_unlock", int'(unlock), 1);
        key(12);
        chk("t5_relock", int'(unlock), 0);
        enter_code(1, 2, 3, 4, 5, 6); key(11);
        chk("t5_old_rej", int'(err_pulse), 1);
        enter_code(6, 5, 4, 3, 2, 1); key(11);
        chk("t5_new_ok", int'(unlock), 1);

        // Aborted change, then reset mid-entry restores default
        key(13); key(9); key(9); key(12);
        chk("t6_abort", int'(unlock), 0);
        enter_code(6, 5, 4, 3, 2, 1); key(11);
        chk("t6_kept", int'(unlock), 1);
        key(12);
        key(1); key(2); key(3);
        do_reset();
        chk("t6_rst_digits", int'(digit_count), 0);
        enter_code(1, 2, 3, 4, 5, 6); key(11);
        chk("t6_default", int'(unlock), 1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 14) begin
                enter_code(m_pw[0], m_pw[1], m_pw[2], m_pw[3], m_pw[4], m_pw[5]);
                key(11);
            end else if (r < 22) begin
                cycle(1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'b1);
            end else if (r < 30) begin
                cycle(1'b0, $urandom_range(0, 15), 1'b0);
            end else begin
                key($urandom_range(0, 15));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
